// File: rtl/hera_stack_pkg.sv
// Shared constants and types for the call/return stack.
// ADDR_W/DATA_W are shared with the PC unit and the RAM wrapper.
// STACK_BASE is the deepest stack slot; the stack grows downward from it.
package hera_stack_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] STACK_BASE = 10'h3FF;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_RD_WAIT
  } state_e;

endpackage

// File: rtl/ret_stack_ctrl_if.sv
// Decoder / PC-unit / data-RAM bus of the return-stack controller.
//   call_req, ret_req : decoder requests (one-cycle pulses)
//   pc                : current PC from the PC unit
//   ram_addr/data/we  : data-RAM port driven by the controller
//   return_pc         : RAM q holds the return address this cycle
//   busy              : return read in flight, decoder holds its request
// master = decoder/PC/RAM side, slave = the controller.
interface ret_stack_ctrl_if #(
  parameter int unsigned ADDR_W = hera_stack_pkg::ADDR_W,
  parameter int unsigned DATA_W = hera_stack_pkg::DATA_W
);

  logic              call_req;
  logic              ret_req;
  logic [DATA_W-1:0] pc;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic              return_pc;
  logic              busy;

  modport master (
    output call_req, ret_req, pc,
    input  ram_addr, ram_data, ram_we, return_pc, busy
  );

  modport slave (
    input  call_req, ret_req, pc,
    output ram_addr, ram_data, ram_we, return_pc, busy
  );

endinterface

// File: rtl/ret_stack_ctrl_stack_ptr.sv
// Stack pointer and occupancy counter for a downward-growing stack.
//   clk, rst_s : clock, synchronous active-high reset
//   push, pop  : accepted operations (never both; caller qualifies them)
//   sp         : next free slot
//   depth_cnt  : entries currently stacked
//   full/empty : depth_cnt == DEPTH / depth_cnt == 0
module stack_ptr #(
  parameter int unsigned       ADDR_W     = hera_stack_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] STACK_BASE = hera_stack_pkg::STACK_BASE,
  parameter int unsigned       DEPTH      = 64,
  parameter int unsigned       CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_s,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp,
  output logic [CNT_W-1:0]  depth_cnt,
  output logic              full,
  output logic              empty
);

  localparam logic [CNT_W-1:0] DepthMax = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] sp_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (rst_s) begin
      sp_q  <= STACK_BASE;
      cnt_q <= '0;
    end else if (push) begin
      sp_q  <= sp_q - ADDR_W'(1);
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop) begin
      sp_q  <= sp_q + ADDR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign sp        = sp_q;
  assign depth_cnt = cnt_q;
  assign full      = (cnt_q == DepthMax);
  assign empty     = (cnt_q == '0);

endmodule

// File: rtl/ret_stack_ctrl.sv
// Call/return stack controller. Pushes pc+1 on a call, reads the stack top on
// a return and raises return_pc one cycle later when RAM q is valid.
//   clk, rst_s : clock, synchronous active-high reset
//   bus        : decoder/PC/RAM bus (slave side)
//   sp         : stack pointer (next free slot)
//   depth_cnt  : entries stacked
//   overflow   : sticky, call while full
//   underflow  : sticky, return while empty
//   proto_err  : sticky, call and return together
module ret_stack_ctrl #(
  parameter int unsigned       ADDR_W     = hera_stack_pkg::ADDR_W,
  parameter int unsigned       DATA_W     = hera_stack_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] STACK_BASE = hera_stack_pkg::STACK_BASE,
  parameter int unsigned       DEPTH      = 64,
  localparam int unsigned      CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_s,
  ret_stack_ctrl_if.slave   bus,
  output logic [ADDR_W-1:0] sp,
  output logic [CNT_W-1:0]  depth_cnt,
  output logic              overflow,
  output logic              underflow,
  output logic              proto_err
);

  import hera_stack_pkg::*;

  state_e state_q;
  logic   return_pc_q;
  logic   busy_q;
  logic   overflow_q;
  logic   underflow_q;
  logic   proto_err_q;
  logic   full;
  logic   empty;
  logic   idle_call;
  logic   idle_ret;
  logic   push;
  logic   pop;

  // Requests only count in IDLE; anything seen in RD_WAIT is dropped.
  assign idle_call = (state_q == ST_IDLE) && !rst_s && bus.call_req && !bus.ret_req;
  assign idle_ret  = (state_q == ST_IDLE) && !rst_s && bus.ret_req && !bus.call_req;
  assign push      = idle_call && !full;
  assign pop       = idle_ret && !empty;

  stack_ptr #(
    .ADDR_W     (ADDR_W),
    .STACK_BASE (STACK_BASE),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W)
  ) u_stack_ptr (
    .clk       (clk),
    .rst_s     (rst_s),
    .push      (push),
    .pop       (pop),
    .sp        (sp),
    .depth_cnt (depth_cnt),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst_s) begin
      state_q     <= ST_IDLE;
      return_pc_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      return_pc_q <= 1'b0;
      busy_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.call_req && bus.ret_req) proto_err_q <= 1'b1;
          if (idle_call && full)           overflow_q  <= 1'b1;
          if (idle_ret && empty)           underflow_q <= 1'b1;
          if (pop) begin
            // q becomes valid after the next edge, so strobe in RD_WAIT.
            state_q     <= ST_RD_WAIT;
            return_pc_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_RD_WAIT: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  // In RD_WAIT sp already points at the popped slot, so ram_addr=sp holds it.
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = sp;
    bus.ram_data = '0;
    if (rst_s) begin
      bus.ram_addr = '0;
    end else if (push) begin
      bus.ram_we   = 1'b1;
      bus.ram_data = bus.pc + DATA_W'(1);
    end else if (pop) begin
      bus.ram_addr = sp + ADDR_W'(1);
    end
  end

  assign bus.return_pc = return_pc_q;
  assign bus.busy      = busy_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;
  assign proto_err     = proto_err_q;

endmodule
